// File: rtl/wash_controller_if.sv
// Key inputs and registered status/actuator outputs of the wash controller.
interface wash_controller_if;
   logic       tick;
   logic       power_key;
   logic       start_key;
   logic       power_light;
   logic [6:0] current_time;
   logic [6:0] total_time;
   logic [2:0] current_water;
   logic [3:0] phase;
   logic       running;
   logic       water_in;
   logic       drain;
   logic       motor;
   logic       buzzer;

   // Front panel / test side: drives keys and tick, observes status.
   modport master (
      output tick, power_key, start_key,
      input  power_light, current_time, total_time, current_water, phase,
      input  running, water_in, drain, motor, buzzer
   );

   // Controller side.
   modport slave (
      input  tick, power_key, start_key,
      output power_light, current_time, total_time, current_water, phase,
      output running, water_in, drain, motor, buzzer
   );
endinterface

// File: rtl/wash_controller.sv
// Washing machine program sequencer: fill, wash, drain, fill, rinse, drain,
// spin, then a timed buzzer before returning to idle. Supports pause/resume
// and a power toggle that overrides everything else.
module wash_controller #(
   parameter int unsigned WASH_T    = 9,
   parameter int unsigned RINSE_T   = 6,
   parameter int unsigned SPIN_T    = 3,
   parameter int unsigned WATER_LVL = 5,
   parameter int unsigned DONE_T    = 3
) (
   input logic              clk,
   input logic              rst_n,
   wash_controller_if.slave bus
);

   typedef enum logic [3:0] {
      OFF    = 4'd0,
      IDLE   = 4'd1,
      FILL1  = 4'd2,
      WASH   = 4'd3,
      DRAIN1 = 4'd4,
      FILL2  = 4'd5,
      RINSE  = 4'd6,
      DRAIN2 = 4'd7,
      SPIN   = 4'd8,
      DONE   = 4'd9
   } state_t;

   localparam logic [6:0] WASH_L  = 7'(WASH_T);
   localparam logic [6:0] RINSE_L = 7'(RINSE_T);
   localparam logic [6:0] SPIN_L  = 7'(SPIN_T);
   localparam logic [6:0] TOTAL_L = 7'(WASH_T + RINSE_T + SPIN_T);
   localparam logic [2:0] WATER_L = 3'(WATER_LVL);
   localparam logic [2:0] DONE_L  = 3'(DONE_T);

   state_t     state_q, state_d;
   logic       paused_q, paused_d;
   logic [6:0] cur_q, cur_d;
   logic [6:0] tot_q, tot_d;
   logic [2:0] water_q, water_d;
   logic [2:0] done_q, done_d;

   logic light_q, light_d;
   logic run_q, run_d;
   logic win_q, win_d;
   logic drn_q, drn_d;
   logic mot_q, mot_d;
   logic buz_q, buz_d;

   // Next-state and counter update: power first, then start, then tick.
   always_comb begin
      state_d  = state_q;
      paused_d = paused_q;
      cur_d    = cur_q;
      tot_d    = tot_q;
      water_d  = water_q;
      done_d   = done_q;

      if (bus.power_key) begin
         paused_d = 1'b0;
         water_d  = '0;
         done_d   = '0;
         if (state_q == OFF) begin
            state_d = IDLE;
            cur_d   = WASH_L;
            tot_d   = TOTAL_L;
         end else begin
            state_d = OFF;
            cur_d   = '0;
            tot_d   = '0;
         end
      end else begin
         case (state_q)
            OFF: begin
            end
            IDLE: begin
               if (bus.start_key) begin
                  state_d  = FILL1;
                  paused_d = 1'b0;
               end
            end
            DONE: begin
               if (bus.tick) begin
                  if (done_q <= 3'd1) begin
                     state_d  = IDLE;
                     done_d   = '0;
                     cur_d    = WASH_L;
                     tot_d    = TOTAL_L;
                     water_d  = '0;
                     paused_d = 1'b0;
                  end else begin
                     done_d = done_q - 3'd1;
                  end
               end
            end
            default: begin
               // Active phases; a start_key in the same cycle swallows the tick.
               if (bus.start_key) begin
                  paused_d = ~paused_q;
               end else if (bus.tick && !paused_q) begin
                  case (state_q)
                     FILL1, FILL2: begin
                        if (water_q >= WATER_L - 3'd1) begin
                           water_d = WATER_L;
                           state_d = (state_q == FILL1) ? WASH : RINSE;
                        end else begin
                           water_d = water_q + 3'd1;
                        end
                     end
                     DRAIN1, DRAIN2: begin
                        if (water_q <= 3'd1) begin
                           water_d = '0;
                           state_d = (state_q == DRAIN1) ? FILL2 : SPIN;
                        end else begin
                           water_d = water_q - 3'd1;
                        end
                     end
                     default: begin
                        tot_d = (tot_q != '0) ? tot_q - 7'd1 : '0;
                        if (cur_q <= 7'd1) begin
                           case (state_q)
                              WASH: begin
                                 state_d = DRAIN1;
                                 cur_d   = RINSE_L;
                              end
                              RINSE: begin
                                 state_d = DRAIN2;
                                 cur_d   = SPIN_L;
                              end
                              default: begin
                                 state_d = DONE;
                                 cur_d   = '0;
                                 done_d  = DONE_L;
                              end
                           endcase
                        end else begin
                           cur_d = cur_q - 7'd1;
                        end
                     end
                  endcase
               end
            end
         endcase
      end
   end

   // Actuator/status decode of the upcoming state so the outputs can be flopped.
   always_comb begin
      light_d = (state_d != OFF);
      run_d   = 1'b0;
      win_d   = 1'b0;
      drn_d   = 1'b0;
      mot_d   = 1'b0;
      buz_d   = (state_d == DONE);
      if (!paused_d) begin
         case (state_d)
            FILL1, FILL2: begin
               run_d = 1'b1;
               win_d = 1'b1;
            end
            DRAIN1, DRAIN2: begin
               run_d = 1'b1;
               drn_d = 1'b1;
            end
            WASH, RINSE, SPIN: begin
               run_d = 1'b1;
               mot_d = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // State, counters and output flops; reset clears everything to OFF.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= OFF;
         paused_q <= 1'b0;
         cur_q    <= '0;
         tot_q    <= '0;
         water_q  <= '0;
         done_q   <= '0;
         light_q  <= 1'b0;
         run_q    <= 1'b0;
         win_q    <= 1'b0;
         drn_q    <= 1'b0;
         mot_q    <= 1'b0;
         buz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         paused_q <= paused_d;
         cur_q    <= cur_d;
         tot_q    <= tot_d;
         water_q  <= water_d;
         done_q   <= done_d;
         light_q  <= light_d;
         run_q    <= run_d;
         win_q    <= win_d;
         drn_q    <= drn_d;
         mot_q    <= mot_d;
         buz_q    <= buz_d;
      end
   end

   assign bus.phase         = state_q;
   assign bus.current_time  = cur_q;
   assign bus.total_time    = tot_q;
   assign bus.current_water = water_q;
   assign bus.power_light   = light_q;
   assign bus.running       = run_q;
   assign bus.water_in      = win_q;
   assign bus.drain         = drn_q;
   assign bus.motor         = mot_q;
   assign bus.buzzer        = buz_q;

endmodule

// File: tb/tb_wash_controller.sv
// Directed bench for wash_controller with default parameters.
module tb_wash_controller;

   logic clk;
   logic rst_n;

   wash_controller_if bus ();

   wash_controller #(
      .WASH_T   (9),
      .RINSE_T  (6),
      .SPIN_T   (3),
      .WATER_LVL(5),
      .DONE_T   (3)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] phase;
      logic [6:0] ct;
      logic [6:0] tt;
      logic [2:0] wl;
      logic       run;
      logic       win;
      logic       drn;
      logic       mot;
      logic       buz;
      logic       pl;
   } outs_t;

   typedef struct {
      bit    p;
      bit    s;
      bit    t;
      outs_t e;
      string nm;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected outputs for a phase number, times, water level and pause flag.
   function automatic outs_t mk(input int ph, input int ct, input int tt, input int w,
                                input bit pz = 1'b0);
      outs_t o;
      bit    act;
      act     = (ph >= 2) && (ph <= 8);
      o.phase = 4'(ph);
      o.ct    = 7'(ct);
      o.tt    = 7'(tt);
      o.wl    = 3'(w);
      o.run   = act && !pz;
      o.win   = (ph == 2 || ph == 5) && !pz;
      o.drn   = (ph == 4 || ph == 7) && !pz;
      o.mot   = (ph == 3 || ph == 6 || ph == 8) && !pz;
      o.buz   = (ph == 9);
      o.pl    = (ph != 0);
      return o;
   endfunction

   function automatic outs_t get_outs();
      outs_t o;
      o.phase = bus.phase;
      o.ct    = bus.current_time;
      o.tt    = bus.total_time;
      o.wl    = bus.current_water;
      o.run   = bus.running;
      o.win   = bus.water_in;
      o.drn   = bus.drain;
      o.mot   = bus.motor;
      o.buz   = bus.buzzer;
      o.pl    = bus.power_light;
      return o;
   endfunction

   task automatic chk(input string nm, input outs_t e);
      outs_t a;
      a = get_outs();
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got ph=%0d ct=%0d tt=%0d w=%0d run/win/drn/mot/buz/pl=%b%b%b%b%b%b, expected ph=%0d ct=%0d tt=%0d w=%0d run/win/drn/mot/buz/pl=%b%b%b%b%b%b",
                  nm, a.phase, a.ct, a.tt, a.wl, a.run, a.win, a.drn, a.mot, a.buz, a.pl,
                  e.phase, e.ct, e.tt, e.wl, e.run, e.win, e.drn, e.mot, e.buz, e.pl);
      end
   endtask

   // One clock with the given key/tick pulses; outputs are stable 1ns after the edge.
   task automatic step(input bit p, input bit s, input bit t);
      @(negedge clk);
      bus.power_key = p;
      bus.start_key = s;
      bus.tick      = t;
      @(posedge clk);
      #1;
      bus.power_key = 1'b0;
      bus.start_key = 1'b0;
      bus.tick      = 1'b0;
   endtask

   // n ticks through one phase: linear change per tick, explicit values after the last.
   task automatic seg(input string nm, input int n, input int ph, input int ct0,
                      input int tt0, input int w0, input int dct, input int dw,
                      input int nph, input int nct, input int ntt, input int nw);
      for (int j = 1; j <= n; j++) begin
         step(1'b0, 1'b0, 1'b1);
         if (j < n) chk(nm, mk(ph, ct0 - dct * j, tt0 - dct * j, w0 + dw * j));
         else       chk(nm, mk(nph, nct, ntt, nw));
      end
   endtask

   vec_t tbl[12];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = '{1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0),        "off_tick"};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0),        "off_start"};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, mk(1, 9, 18, 0),       "power_on"};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, mk(1, 9, 18, 0),       "idle_tick"};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, mk(2, 9, 18, 0),       "start"};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, mk(2, 9, 18, 1),       "fill_tick"};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, mk(2, 9, 18, 1, 1'b1), "pause"};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, mk(2, 9, 18, 1, 1'b1), "paused_tick"};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, mk(2, 9, 18, 1),       "resume_drops_tick"};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, mk(2, 9, 18, 2),       "fill_tick2"};
      tbl[10] = '{1'b1, 1'b1, 1'b1, mk(0, 0, 0, 0),        "power_priority"};
      tbl[11] = '{1'b1, 1'b0, 1'b0, mk(1, 9, 18, 0),       "power_on2"};

      rst_n         = 1'b0;
      bus.tick      = 1'b0;
      bus.power_key = 1'b0;
      bus.start_key = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", mk(0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         step(tbl[i].p, tbl[i].s, tbl[i].t);
         chk(tbl[i].nm, tbl[i].e);
      end

      // Full program, 60 ticks from start.
      step(1'b0, 1'b1, 1'b0);
      chk("run_start", mk(2, 9, 18, 0));
      seg("fill1",  5, 2, 9, 18, 5 - 5, 0,  1, 3, 9, 18, 5);
      seg("wash",   9, 3, 9, 18, 5,     1,  0, 4, 6,  9, 5);
      seg("drain1", 5, 4, 6,  9, 5,     0, -1, 5, 6,  9, 0);
      seg("fill2",  5, 5, 6,  9, 0,     0,  1, 6, 6,  9, 5);
      seg("rinse",  6, 6, 6,  9, 5,     1,  0, 7, 3,  3, 5);
      seg("drain2", 5, 7, 3,  3, 5,     0, -1, 8, 3,  3, 0);
      seg("spin",   3, 8, 3,  3, 0,     1,  0, 9, 0,  0, 0);
      seg("done",   3, 9, 0,  0, 0,     0,  0, 1, 9, 18, 0);
      seg("idle",  19, 1, 9, 18, 0,     0,  0, 1, 9, 18, 0);

      // Pause in WASH at 4/13.
      step(1'b0, 1'b1, 1'b0);
      chk("b_start", mk(2, 9, 18, 0));
      seg("b_fill1", 5, 2, 9, 18, 0, 0, 1, 3, 9, 18, 5);
      seg("b_wash",  5, 3, 9, 18, 5, 1, 0, 3, 4, 13, 5);
      step(1'b0, 1'b1, 1'b0);
      chk("b_pause", mk(3, 4, 13, 5, 1'b1));
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 1'b0, 1'b1);
         chk("b_frozen", mk(3, 4, 13, 5, 1'b1));
      end
      step(1'b0, 1'b1, 1'b0);
      chk("b_resume", mk(3, 4, 13, 5));
      step(1'b0, 1'b0, 1'b1);
      chk("b_tick", mk(3, 3, 12, 5));

      // start_key with tick in RINSE.
      seg("c_wash",   3, 3, 3, 12, 5, 1,  0, 4, 6, 9, 5);
      seg("c_drain1", 5, 4, 6,  9, 5, 0, -1, 5, 6, 9, 0);
      seg("c_fill2",  5, 5, 6,  9, 0, 0,  1, 6, 6, 9, 5);
      step(1'b0, 1'b0, 1'b1);
      chk("c_rinse_tick", mk(6, 5, 8, 5));
      step(1'b0, 1'b1, 1'b1);
      chk("c_pause_tick", mk(6, 5, 8, 5, 1'b1));
      step(1'b0, 1'b1, 1'b0);
      chk("c_resume", mk(6, 5, 8, 5));

      // power_key with start_key in SPIN.
      seg("d_rinse",  5, 6, 5, 8, 5, 1,  0, 7, 3, 3, 5);
      seg("d_drain2", 5, 7, 3, 3, 5, 0, -1, 8, 3, 3, 0);
      step(1'b0, 1'b0, 1'b1);
      chk("d_spin_tick", mk(8, 2, 2, 0));
      step(1'b1, 1'b1, 1'b0);
      chk("d_power_off", mk(0, 0, 0, 0));

      // Asynchronous reset in FILL2 with water 3.
      step(1'b1, 1'b0, 1'b0);
      chk("e_power", mk(1, 9, 18, 0));
      step(1'b0, 1'b1, 1'b0);
      chk("e_start", mk(2, 9, 18, 0));
      seg("e_fill1",  5, 2, 9, 18, 0, 0,  1, 3, 9, 18, 5);
      seg("e_wash",   9, 3, 9, 18, 5, 1,  0, 4, 6,  9, 5);
      seg("e_drain1", 5, 4, 6,  9, 5, 0, -1, 5, 6,  9, 0);
      seg("e_fill2",  3, 5, 6,  9, 0, 0,  1, 5, 6,  9, 3);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("e_async_reset", mk(0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 1'b1, 1'b0);
      chk("e_start_ignored", mk(0, 0, 0, 0));
      step(1'b0, 1'b0, 1'b1);
      chk("e_tick_ignored", mk(0, 0, 0, 0));
      step(1'b1, 1'b0, 1'b0);
      chk("e_power_on", mk(1, 9, 18, 0));
      step(1'b0, 1'b1, 1'b0);
      chk("e_start_ok", mk(2, 9, 18, 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
